// File: rtl/vxe_axi4slv_mem_if.sv
// AXI4 bus bundle between a VxEngine master and the scratch-memory slave.
// Signal names keep the S_AXI4_* prefix used across the SoC so waveforms and
// netlists line up with the rest of the fabric.
//
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where VALID and READY are both 1. The VALID side holds its payload stable
// until that edge, and it never waits for READY before raising VALID.
interface vxe_axi4slv_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8
);
   localparam int BYTES = DATA_WIDTH / 8;

   // write address
   logic [ID_WIDTH-1:0]   S_AXI4_AWID;
   logic [ADDR_WIDTH-1:0] S_AXI4_AWADDR;
   logic [7:0]            S_AXI4_AWLEN;
   logic [2:0]            S_AXI4_AWSIZE;
   logic [1:0]            S_AXI4_AWBURST;
   logic                  S_AXI4_AWVALID;
   logic                  S_AXI4_AWREADY;
   // write data
   logic [DATA_WIDTH-1:0] S_AXI4_WDATA;
   logic [BYTES-1:0]      S_AXI4_WSTRB;
   logic                  S_AXI4_WLAST;
   logic                  S_AXI4_WVALID;
   logic                  S_AXI4_WREADY;
   // write response
   logic [ID_WIDTH-1:0]   S_AXI4_BID;
   logic [1:0]            S_AXI4_BRESP;
   logic                  S_AXI4_BVALID;
   logic                  S_AXI4_BREADY;
   // read address
   logic [ID_WIDTH-1:0]   S_AXI4_ARID;
   logic [ADDR_WIDTH-1:0] S_AXI4_ARADDR;
   logic [7:0]            S_AXI4_ARLEN;
   logic [2:0]            S_AXI4_ARSIZE;
   logic [1:0]            S_AXI4_ARBURST;
   logic                  S_AXI4_ARVALID;
   logic                  S_AXI4_ARREADY;
   // read data
   logic [ID_WIDTH-1:0]   S_AXI4_RID;
   logic [DATA_WIDTH-1:0] S_AXI4_RDATA;
   logic [1:0]            S_AXI4_RRESP;
   logic                  S_AXI4_RLAST;
   logic                  S_AXI4_RVALID;
   logic                  S_AXI4_RREADY;

   modport master (
      output S_AXI4_AWID, S_AXI4_AWADDR, S_AXI4_AWLEN, S_AXI4_AWSIZE, S_AXI4_AWBURST, S_AXI4_AWVALID,
      input  S_AXI4_AWREADY,
      output S_AXI4_WDATA, S_AXI4_WSTRB, S_AXI4_WLAST, S_AXI4_WVALID,
      input  S_AXI4_WREADY,
      input  S_AXI4_BID, S_AXI4_BRESP, S_AXI4_BVALID,
      output S_AXI4_BREADY,
      output S_AXI4_ARID, S_AXI4_ARADDR, S_AXI4_ARLEN, S_AXI4_ARSIZE, S_AXI4_ARBURST, S_AXI4_ARVALID,
      input  S_AXI4_ARREADY,
      input  S_AXI4_RID, S_AXI4_RDATA, S_AXI4_RRESP, S_AXI4_RLAST, S_AXI4_RVALID,
      output S_AXI4_RREADY
   );

   modport slave (
      input  S_AXI4_AWID, S_AXI4_AWADDR, S_AXI4_AWLEN, S_AXI4_AWSIZE, S_AXI4_AWBURST, S_AXI4_AWVALID,
      output S_AXI4_AWREADY,
      input  S_AXI4_WDATA, S_AXI4_WSTRB, S_AXI4_WLAST, S_AXI4_WVALID,
      output S_AXI4_WREADY,
      output S_AXI4_BID, S_AXI4_BRESP, S_AXI4_BVALID,
      input  S_AXI4_BREADY,
      input  S_AXI4_ARID, S_AXI4_ARADDR, S_AXI4_ARLEN, S_AXI4_ARSIZE, S_AXI4_ARBURST, S_AXI4_ARVALID,
      output S_AXI4_ARREADY,
      output S_AXI4_RID, S_AXI4_RDATA, S_AXI4_RRESP, S_AXI4_RLAST, S_AXI4_RVALID,
      input  S_AXI4_RREADY
   );
endinterface

// File: rtl/vxe_axi4slv_mem.sv
// AXI4 slave responder backed by a word-addressed scratch memory.
// Independent write and read FSMs share one array (one write port, one read
// port). Only aligned full-width beats are supported; AxSIZE is ignored.
// Responses: DECERR (address beyond the array) > SLVERR (WRAP/reserved burst,
// or WLAST disagreeing with the beat count) > OKAY.
module vxe_axi4slv_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int MEM_AWIDTH = 10
) (
   input  logic                  M_AXI4_ACLK,
   input  logic                  M_AXI4_ARESETn,
   vxe_axi4slv_mem_if.slave      s_axi4,
   output logic [1:0]            w_state_dbg,
   output logic [1:0]            r_state_dbg
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LB    = $clog2(BYTES);
   localparam int HI    = LB + MEM_AWIDTH;   // first address bit outside the array
   localparam int DEPTH = 1 << MEM_AWIDTH;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_DATA = 2'd1;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   function automatic logic [MEM_AWIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[HI-1:LB];
   endfunction

   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
      return (a >> HI) != '0;
   endfunction

   // FIXED holds the address; only INCR advances (errored bursts just hold)
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] burst);
      return (burst == BURST_INCR) ? a + ADDR_WIDTH'(BYTES) : a;
   endfunction

   // AxSIZE carries no meaning for full-width-only beats
   logic unused_size;
   assign unused_size = ^{s_axi4.S_AXI4_AWSIZE, s_axi4.S_AXI4_ARSIZE};

   // ---------------- write path ----------------
   logic [1:0]            w_state;
   logic                  aw_ready, w_ready, b_valid;
   logic [ID_WIDTH-1:0]   w_id, b_id;
   logic [1:0]            b_resp, w_err;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len, w_beat;
   logic [1:0]            w_burst;

   logic       w_hs, w_last_beat, w_decerr, w_bad, mem_we;
   logic [1:0] w_beat_resp, w_err_next;

   assign w_hs        = w_ready && s_axi4.S_AXI4_WVALID;
   assign w_last_beat = (w_beat == w_len);
   assign w_decerr    = out_of_range(w_addr);
   assign w_bad       = w_burst[1];
   assign mem_we      = w_hs && !w_decerr && !w_bad;

   // per-beat write response and running worst-case for BRESP
   always_comb begin
      w_beat_resp = RESP_OKAY;
      if (w_decerr)
         w_beat_resp = RESP_DECERR;
      else if (w_bad || (s_axi4.S_AXI4_WLAST != w_last_beat))
         w_beat_resp = RESP_SLVERR;
      w_err_next = (w_beat_resp > w_err) ? w_beat_resp : w_err;
   end

   // write FSM: AW accept, W beats, B response
   always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
      if (!M_AXI4_ARESETn) begin
         w_state  <= W_IDLE;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_id     <= '0;
         b_resp   <= RESP_OKAY;
         w_id     <= '0;
         w_addr   <= '0;
         w_len    <= '0;
         w_burst  <= '0;
         w_beat   <= '0;
         w_err    <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_ready && s_axi4.S_AXI4_AWVALID) begin
                  w_id     <= s_axi4.S_AXI4_AWID;
                  w_addr   <= s_axi4.S_AXI4_AWADDR;
                  w_len    <= s_axi4.S_AXI4_AWLEN;
                  w_burst  <= s_axi4.S_AXI4_AWBURST;
                  w_beat   <= '0;
                  w_err    <= RESP_OKAY;
                  aw_ready <= 1'b0;
                  w_ready  <= 1'b1;
                  w_state  <= W_DATA;
               end else begin
                  aw_ready <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_addr <= next_addr(w_addr, w_burst);
                  // the beat count, not WLAST, ends the burst
                  if (w_last_beat) begin
                     w_ready <= 1'b0;
                     b_valid <= 1'b1;
                     b_id    <= w_id;
                     b_resp  <= w_err_next;
                     w_state <= W_RESP;
                  end else begin
                     w_beat <= w_beat + 8'd1;
                     w_err  <= w_err_next;
                  end
               end
            end
            W_RESP: begin
               if (s_axi4.S_AXI4_BREADY) begin
                  b_valid  <= 1'b0;
                  aw_ready <= 1'b1;
                  w_state  <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // byte-lane memory write; contents are deliberately not reset
   always_ff @(posedge M_AXI4_ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (s_axi4.S_AXI4_WSTRB[i])
               mem[word_idx(w_addr)][8*i +: 8] <= s_axi4.S_AXI4_WDATA[8*i +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   logic [1:0]            r_state;
   logic                  ar_ready, r_valid, r_last;
   logic [ID_WIDTH-1:0]   r_id;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_resp;
   logic [ADDR_WIDTH-1:0] r_addr;      // address of the next beat to load
   logic [7:0]            r_len, r_beat, r_beat_nxt;
   logic [1:0]            r_burst;

   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [1:0]            rd_burst, rd_resp;
   logic [DATA_WIDTH-1:0] rd_data;

   assign r_beat_nxt = r_beat + 8'd1;

   // data/response of the beat being loaded into the output register
   always_comb begin
      rd_addr  = r_addr;
      rd_burst = r_burst;
      if (r_state == R_IDLE) begin
         rd_addr  = s_axi4.S_AXI4_ARADDR;
         rd_burst = s_axi4.S_AXI4_ARBURST;
      end
      rd_resp = RESP_OKAY;
      rd_data = mem[word_idx(rd_addr)];
      if (out_of_range(rd_addr)) begin
         rd_resp = RESP_DECERR;
         rd_data = '0;
      end else if (rd_burst[1]) begin
         rd_resp = RESP_SLVERR;
         rd_data = '0;
      end
   end

   // read FSM: AR accept, then one R beat per RREADY cycle
   always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
      if (!M_AXI4_ARESETn) begin
         r_state  <= R_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_id     <= '0;
         r_data   <= '0;
         r_resp   <= RESP_OKAY;
         r_addr   <= '0;
         r_len    <= '0;
         r_burst  <= '0;
         r_beat   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_ready && s_axi4.S_AXI4_ARVALID) begin
                  r_id     <= s_axi4.S_AXI4_ARID;
                  r_len    <= s_axi4.S_AXI4_ARLEN;
                  r_burst  <= s_axi4.S_AXI4_ARBURST;
                  r_addr   <= next_addr(s_axi4.S_AXI4_ARADDR, s_axi4.S_AXI4_ARBURST);
                  r_beat   <= '0;
                  r_valid  <= 1'b1;
                  r_data   <= rd_data;
                  r_resp   <= rd_resp;
                  r_last   <= (s_axi4.S_AXI4_ARLEN == 8'd0);
                  ar_ready <= 1'b0;
                  r_state  <= R_DATA;
               end else begin
                  ar_ready <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_valid && s_axi4.S_AXI4_RREADY) begin
                  if (r_last) begin
                     r_valid  <= 1'b0;
                     r_last   <= 1'b0;
                     ar_ready <= 1'b1;
                     r_state  <= R_IDLE;
                  end else begin
                     r_beat <= r_beat_nxt;
                     r_data <= rd_data;
                     r_resp <= rd_resp;
                     r_last <= (r_beat_nxt == r_len);
                     r_addr <= next_addr(r_addr, r_burst);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign s_axi4.S_AXI4_AWREADY = aw_ready;
   assign s_axi4.S_AXI4_WREADY  = w_ready;
   assign s_axi4.S_AXI4_BID     = b_id;
   assign s_axi4.S_AXI4_BRESP   = b_resp;
   assign s_axi4.S_AXI4_BVALID  = b_valid;
   assign s_axi4.S_AXI4_ARREADY = ar_ready;
   assign s_axi4.S_AXI4_RID     = r_id;
   assign s_axi4.S_AXI4_RDATA   = r_data;
   assign s_axi4.S_AXI4_RRESP   = r_resp;
   assign s_axi4.S_AXI4_RLAST   = r_last;
   assign s_axi4.S_AXI4_RVALID  = r_valid;

   assign w_state_dbg = w_state;
   assign r_state_dbg = r_state;

endmodule
